// File: rtl/dut_ram.sv
// dut_ram: single-clock RAM with per-entry valid bits and a registered
// read port that reads every cycle and flags same-address collisions.
//
// Parameters:
//   D_WIDTH        data word width in bits
//   A_WIDTH        address width; depth is 2**A_WIDTH entries
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset; clears valid bits/outputs
//   address_write  write address
//   data_write     write data
//   write_enable   write strobe, active high
//   address_read   read address, sampled every cycle
//   data_read      registered read data (0 for never-written entries)
//   read_valid     registered: entry read last cycle was written since reset
//   collision      registered: same-address read and write last cycle
// Build option:
//   DUT_RAM_BYPASS_EN  when defined, a same-cycle same-address write is
//                      forwarded to the read port (write-first); otherwise
//                      the read returns the old contents (read-first).
module dut_ram #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [A_WIDTH-1:0] address_write,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic               write_enable,
    input  logic [A_WIDTH-1:0] address_read,
    output logic [D_WIDTH-1:0] data_read,
    output logic               read_valid,
    output logic               collision
);

    localparam int DEPTH = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid;

    logic               wr_go;
    logic               same_addr;
    logic               rd_hit;
    logic [D_WIDTH-1:0] data_nxt;
    logic               valid_nxt;

    // Writes are suppressed while reset is held; the word array itself
    // is never cleared because the valid bits gate every read.
    assign wr_go     = write_enable & rst_n;
    assign same_addr = write_enable & (address_write == address_read);
    assign rd_hit    = valid[address_read];

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[address_write] <= data_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (write_enable) begin
            valid[address_write] <= 1'b1;
        end
    end

    // Read-side next value: old contents gated by the old valid bit,
    // optionally overridden by the in-flight write.
    always_comb begin
        data_nxt  = '0;
        valid_nxt = rd_hit;
        if (rd_hit) begin
            data_nxt = mem[address_read];
        end
`ifdef DUT_RAM_BYPASS_EN
        if (same_addr) begin
            data_nxt  = data_write;
            valid_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_read  <= '0;
            read_valid <= 1'b0;
            collision  <= 1'b0;
        end else begin
            data_read  <= data_nxt;
            read_valid <= valid_nxt;
            collision  <= same_addr;
        end
    end

endmodule

// File: tb/tb_dut_ram.sv
// tb_dut_ram: randomized and directed checks of dut_ram against an
// array-based model of the RAM contents and valid bits.
module tb_dut_ram;

    logic        clk;
    logic        rst_n;
    logic [4:0]  address_write;
    logic [15:0] data_write;
    logic        write_enable;
    logic [4:0]  address_read;
    logic [15:0] data_read;
    logic        read_valid;
    logic        collision;

    dut_ram #(.D_WIDTH(16), .A_WIDTH(5)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address_write(address_write),
        .data_write   (data_write),
        .write_enable (write_enable),
        .address_read (address_read),
        .data_read    (data_read),
        .read_valid   (read_valid),
        .collision    (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DUT_RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mm [32];
    logic        mv [32];

    logic [15:0] x_data, e_data;
    logic        x_valid, e_valid;
    logic        x_col, e_col;
    logic        armed = 1'b0;
    logic        e_chk = 1'b0;

    // Expected outputs for the cycle just driven become due after the edge.
    always @(posedge clk) begin
        e_data  <= x_data;
        e_valid <= x_valid;
        e_col   <= x_col;
        e_chk   <= armed;
    end

    always @(negedge clk) begin
        if (e_chk && rst_n) begin
            n_vec++;
            if (data_read !== e_data || read_valid !== e_valid ||
                collision !== e_col) begin
                n_err++;
                $display("FAIL model t=%0t got d=%h v=%b c=%b want d=%h v=%b c=%b",
                         $time, data_read, read_valid, collision,
                         e_data, e_valid, e_col);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] got,
                       input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Drive one cycle of stimulus and work out what the read port must
    // show after the next rising edge.
    task automatic cyc(input logic we, input logic [4:0] aw,
                       input logic [15:0] dw, input logic [4:0] ar);
        @(negedge clk);
        write_enable  = we;
        address_write = aw;
        data_write    = dw;
        address_read  = ar;
        x_col = we && (aw == ar);
        if (BYP && x_col) begin
            x_data  = dw;
            x_valid = 1'b1;
        end else begin
            x_valid = mv[ar];
            x_data  = mv[ar] ? mm[ar] : 16'h0;
        end
        if (we) begin
            mm[aw] = dw;
            mv[aw] = 1'b1;
        end
        armed = 1'b1;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        write_enable  = 1'b0;
        address_write = '0;
        data_write    = '0;
        address_read  = '0;
        x_data = '0; x_valid = 1'b0; x_col = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mm[i] = '0;
            mv[i] = 1'b0;
        end
        #1;
        lit("rst_data", data_read, 16'h0);
        lit("rst_flags", {14'h0, read_valid, collision}, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Every entry reads back as invalid zero after reset.
        for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 16'h0, 5'(i));
        after_edge();
        lit("empty31_v", {15'h0, read_valid}, 16'h0);

        cyc(1'b1, 5'd3, 16'hA5A5, 5'd0);
        cyc(1'b0, 5'd0, 16'h0, 5'd3);
        after_edge();
        lit("rd3_data", data_read, 16'hA5A5);
        lit("rd3_valid", {15'h0, read_valid}, 16'h1);

        cyc(1'b1, 5'd7, 16'h1111, 5'd0);
        cyc(1'b1, 5'd7, 16'h2222, 5'd7);
        after_edge();
        lit("col7_flag", {15'h0, collision}, 16'h1);
        lit("col7_data", data_read, BYP ? 16'h2222 : 16'h1111);
        cyc(1'b0, 5'd0, 16'h0, 5'd7);
        after_edge();
        lit("rd7_after", data_read, 16'h2222);
        lit("rd7_nocol", {15'h0, collision}, 16'h0);

        cyc(1'b1, 5'd31, 16'hBEEF, 5'd0);
        cyc(1'b1, 5'd0, 16'h0001, 5'd0);
        cyc(1'b0, 5'd0, 16'h0, 5'd31);
        after_edge();
        lit("rd31", data_read, 16'hBEEF);
        cyc(1'b0, 5'd0, 16'h0, 5'd0);
        after_edge();
        lit("rd0", data_read, 16'h0001);

        cyc(1'b1, 5'd10, 16'h0A0A, 5'd0);
        cyc(1'b1, 5'd9, 16'h0909, 5'd10);
        after_edge();
        lit("w9r10_col", {15'h0, collision}, 16'h0);
        lit("w9r10_data", data_read, 16'h0A0A);

        // Mid-cycle reset wipes everything, and writes during it are lost.
        cyc(1'b1, 5'd5, 16'h1234, 5'd0);
        cyc(1'b0, 5'd0, 16'h0, 5'd5);
        after_edge();
        lit("rd5_pre", data_read, 16'h1234);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        armed = 1'b0;
        #1;
        lit("async_data", data_read, 16'h0);
        lit("async_flags", {14'h0, read_valid, collision}, 16'h0);
        write_enable  = 1'b1;
        address_write = 5'd5;
        data_write    = 16'hFFFF;
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        write_enable = 1'b0;
        rst_n = 1'b1;
        cyc(1'b0, 5'd0, 16'h0, 5'd5);
        after_edge();
        lit("rd5_post_d", data_read, 16'h0);
        lit("rd5_post_v", {15'h0, read_valid}, 16'h0);

        // Random traffic, biased toward same-address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] aw, ar;
            aw = 5'($urandom_range(0, 31));
            ar = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
            cyc(1'($urandom_range(0, 1)), aw, 16'($urandom), ar);
        end
        @(negedge clk);
        armed = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dut_ram.md
DUT_RAM -- requirements
Module: dut_ram

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter A_WIDTH, default 5, address width; depth = 2**A_WIDTH entries (32 by default).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; both ports below are named clk and rst_n.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port address_write, input, A_WIDTH, write address.
REQ-007 SHALL have port data_write, input, D_WIDTH, write data.
REQ-008 SHALL have port write_enable, input, 1, write strobe, active high.
REQ-009 SHALL have port address_read, input, A_WIDTH, read address, sampled every cycle.
REQ-010 SHALL have port data_read, output, D_WIDTH, registered read data.
REQ-011 SHALL have port read_valid, output, 1, registered flag: the entry read last cycle had been written since reset.
REQ-012 SHALL have port collision, output, 1, registered flag: same-address read and write occurred last cycle.

Function
REQ-013 SHALL store 2**A_WIDTH words of D_WIDTH bits plus one valid bit per entry.
REQ-014 SHALL, on rising clk with write_enable=1, write data_write to entry address_write and set its valid bit.
REQ-015 SHALL, with write_enable=0, leave memory and valid bits unchanged.
REQ-016 SHALL perform a read every cycle: data_read = entry[address_read] if its valid bit is set, else 0; read_valid = that valid bit.
REQ-017 SHALL present read results exactly 1 cycle after address_read is sampled; there is no read enable.
REQ-018 SHALL, on a same-cycle write and read to the same address without BYPASS, return the old contents (read-first), using the old valid bit.
REQ-019 SHALL set collision = write_enable AND (address_write == address_read) for the sampled cycle, independent of BYPASS.
REQ-020 SHALL treat read and write at different addresses in the same cycle as fully independent.
REQ-021 SHALL decode all 2**A_WIDTH addresses; no wrap-around or out-of-range case exists.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronously), force data_read=0, read_valid=0, collision=0 and clear all valid bits.
REQ-023 SHALL ignore write_enable while rst_n=0; memory word contents need not be cleared because the valid bits gate all read data.
REQ-024 SHALL resume normal operation on the first rising clk after rst_n deasserts; a reset asserted mid-operation discards all stored data.

Configuration
REQ-025 SHALL, when macro DUT_RAM_BYPASS_EN is defined, forward data_write to data_read with read_valid=1 on a same-cycle same-address write and read (write-first).
REQ-026 SHALL, when DUT_RAM_BYPASS_EN is undefined, use the read-first behaviour of REQ-018.

Verification
REQ-027 Reset, then read addresses 0..31 -> data_read=0 and read_valid=0 for every address.
REQ-028 Write 0xA5A5 to address 3, then read address 3 -> data_read=0xA5A5 one cycle after the read address is sampled, read_valid=1.
REQ-029 Address 7 holds 0x1111; write 0x2222 to 7 while reading 7 -> collision=1; data_read=0x1111 without the macro, 0x2222 with DUT_RAM_BYPASS_EN.
REQ-030 Write 0xBEEF to address 31 and 0x0001 to address 0, then read both -> each returns its own value, no aliasing.
REQ-031 Write 0x1234 to address 5, pulse rst_n low mid-cycle, then read address 5 -> outputs are 0 immediately on assertion; after release, data_read=0 and read_valid=0.
REQ-032 Write to address 9 while reading address 10 -> collision=0, and the read of address 10 is unaffected.
